spi_bus_bridge: RTL and testbench
=================================

// Module: spi_bus_bridge
// PURPOSE
//  SPI slave (mode 0, MSB first) that converts host SPI frames into the parallel register bus of main
//  (rdaddr/wraddr/be/write/wrdata/rddata). Sits directly upstream of main; the MCU reaches all register banks through it.
//  Frame = 16-bit header {rw, addr[14:0]} followed by any number of 16-bit data words, address auto-incrementing.
// PARAMETERS
//  SYNC_STAGES  2   synchronizer flops on spi_sck, spi_csn, spi_mosi
//  RD_LAT       2   clk cycles from rdaddr change to valid rddata (main registers rddata once; sub-banks add one)
// PORTS
//  clk        in   1   system clock; sole clock
//  sclr       in   1   reset; synchronous, active-high
//  spi_sck    in   1   SPI clock, async to clk; period >= 16 clk
//  spi_csn    in   1   SPI chip select, active low, async
//  spi_mosi   in   1   SPI data in, async
//  spi_miso   out  1   SPI data out
//  rdaddr     out  16  read word address to main
//  wraddr     out  16  write word address to main
//  be         out  2   byte enables; always 2'b11 with write
//  write      out  1   one-clk write strobe
//  wrdata     out  16  write data
//  rddata     in   16  read data from main, valid RD_LAT clks after rdaddr
//  busy       out  1   high while a frame is open (csn low, state != IDLE)
//  frame_err  out  1   one-clk pulse: csn rose with partial word (bit_cnt != 0)
// BEHAVIOUR
//  - Reset (sclr): all outputs 0, rdaddr=wraddr=0, state=WAIT_CS; sclr dominates every other event.
//  - Inputs pass SYNC_STAGES flops; sck_rise/sck_fall/cs_fall/cs_rise are 1-clk pulses from last two sync stages.
//  - States: WAIT_CS -> IDLE when synced csn=1. IDLE -> HDR on cs_fall (bit_cnt=0, shreg=0).
//    HDR: shift mosi on sck_rise; at 16th bit latch rw=bit15, addr={1'b0,bits14:0};
//    -> WDATA if rw=1; -> RDATA if rw=0 (rdaddr<=addr same clk as header completes).
//    WDATA: on each 16th bit: wrdata<=word, wraddr<=addr, be<=2'b11, write=1 next clk for exactly 1 clk, addr<=addr+1.
//    RDATA: RD_LAT clks after rdaddr update capture rddata into hold reg, then rdaddr<=rdaddr+1 (prefetch).
//      On header completion and on each 16th data bit: shift-out reg <= hold reg; next prefetch starts.
//    Any state: cs_rise -> IDLE; if bit_cnt!=0 pulse frame_err, discard partial word (no write).
//  - Address arithmetic mod 2^16: 16'hFFFF + 1 = 16'h0000 (write and read paths).
//  - spi_miso: 0 in IDLE/WAIT_CS/HDR; in RDATA = shift-out MSB, shifted left on sck_fall,
//    new word MSB driven on the clk after load. Host samples on rising edge.
//  - Reads have no side effects in main; one extra prefetch read at frame end is allowed.
//  - Timing budget: header 16th rise -> MISO MSB valid within SYNC_STAGES+RD_LAT+3 clks < half SCK period.
//  - bit_cnt 4-bit, wraps 15->0 each word; cs_fall while busy (glitch) restarts HDR.
//  - sclr mid-frame: -> WAIT_CS; rest of frame ignored until csn high then low again.
// TESTING
//  1. Write frame hdr=16'h8180, data=16'h1234 -> one write pulse, wraddr=16'h0180, wrdata=16'h1234, be=2'b11.
//  2. Burst write hdr=16'hFFFF, 3 words A,B,C -> writes at 16'h7FFF,16'h8000,16'h8001; addr+1 of 16'hFFFF (forced) -> 0.
//  3. Read hdr=16'h0100, bus model returns addr^16'h5A5A after RD_LAT -> MISO word 16'h5B5A; write never asserted.
//  4. Burst read 4 words from 16'h01C0 -> MISO 4 consecutive model words; rdaddr ends at 16'h01C4.
//  5. csn rises after 9 data bits of a write -> frame_err 1 clk, no write pulse, busy=0, next frame works.
//  6. sclr mid write word -> all outputs 0; remaining SCK edges ignored; write only after csn high->low new frame.

Source files
------------

// File: rtl/spi_bus_bridge.sv
// SPI mode-0 slave that turns host frames ({rw, addr[14:0]} header plus data words)
// into reads and writes on the parallel register bus of main, auto-incrementing the address.
module spi_bus_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_LAT      = 2
) (
    input  logic        clk,
    input  logic        sclr,
    input  logic        spi_sck,
    input  logic        spi_csn,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [15:0] rdaddr,
    output logic [15:0] wraddr,
    output logic [1:0]  be,
    output logic        write,
    output logic [15:0] wrdata,
    input  logic [15:0] rddata,
    output logic        busy,
    output logic        frame_err
);

    localparam int unsigned DW    = 16;
    localparam int unsigned BCW   = 4;
    localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        WAIT_CS,
        IDLE,
        HDR,
        WDATA,
        RDATA
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [BCW-1:0]         bit_cnt;
    logic [DW-2:0]          shreg;
    logic [DW-1:0]          addr;
    logic [DW-1:0]          shout;
    logic                   fetch;
    logic [LAT_W-1:0]       lat_cnt;

    logic          sck_rise;
    logic          sck_fall;
    logic          cs_rise;
    logic          cs_fall;
    logic          word_done;
    logic [DW-1:0] word_in;

    // csn chain resets low so a reset taken mid-frame cannot look like an idle bus
    always_ff @(posedge clk) begin
        if (sclr) begin
            sck_sync  <= '0;
            csn_sync  <= '0;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign sck_rise  =  sck_sync[SYNC_STAGES-2] & ~sck_sync[SYNC_STAGES-1];
    assign sck_fall  = ~sck_sync[SYNC_STAGES-2] &  sck_sync[SYNC_STAGES-1];
    assign cs_rise   =  csn_sync[SYNC_STAGES-2] & ~csn_sync[SYNC_STAGES-1];
    assign cs_fall   = ~csn_sync[SYNC_STAGES-2] &  csn_sync[SYNC_STAGES-1];
    assign word_in   = {shreg, mosi_sync[SYNC_STAGES-1]};
    assign word_done = sck_rise && (bit_cnt == BCW'(15));

    always_ff @(posedge clk) begin
        if (sclr) begin
            state     <= WAIT_CS;
            bit_cnt   <= '0;
            shreg     <= '0;
            addr      <= '0;
            shout     <= '0;
            fetch     <= 1'b0;
            lat_cnt   <= '0;
            rdaddr    <= '0;
            wraddr    <= '0;
            wrdata    <= '0;
            be        <= '0;
            write     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            spi_miso  <= 1'b0;
        end else begin
            write     <= 1'b0;
            frame_err <= 1'b0;
            spi_miso  <= (state == RDATA) ? shout[DW-1] : 1'b0;

            // Read fetch: rddata is sampled RD_LAT+1 edges after rdaddr was registered
            if (fetch) begin
                if (lat_cnt == LAT_W'(RD_LAT)) begin
                    shout <= rddata;
                    fetch <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                end
            end

            if (cs_rise) begin
                state   <= IDLE;
                busy    <= 1'b0;
                fetch   <= 1'b0;
                bit_cnt <= '0;
                if (bit_cnt != '0) begin
                    frame_err <= 1'b1;
                end
            end else if (cs_fall && state != WAIT_CS) begin
                state   <= HDR;
                busy    <= 1'b1;
                bit_cnt <= '0;
                shreg   <= '0;
                fetch   <= 1'b0;
                shout   <= '0;
            end else begin
                if (sck_rise && (state == HDR || state == WDATA || state == RDATA)) begin
                    bit_cnt <= bit_cnt + BCW'(1);
                    shreg   <= word_in[DW-2:0];
                end
                case (state)
                    WAIT_CS: begin
                        if (csn_sync[SYNC_STAGES-1]) begin
                            state <= IDLE;
                        end
                    end
                    IDLE: begin
                    end
                    HDR: begin
                        if (word_done) begin
                            addr <= {1'b0, word_in[DW-2:0]};
                            if (word_in[DW-1]) begin
                                state <= WDATA;
                            end else begin
                                state   <= RDATA;
                                rdaddr  <= {1'b0, word_in[DW-2:0]};
                                fetch   <= 1'b1;
                                lat_cnt <= '0;
                            end
                        end
                    end
                    WDATA: begin
                        if (word_done) begin
                            wrdata <= word_in;
                            wraddr <= addr;
                            be     <= 2'b11;
                            write  <= 1'b1;
                            addr   <= addr + DW'(1);
                        end
                    end
                    RDATA: begin
                        // The fall right after a word boundary keeps the freshly loaded MSB
                        if (word_done) begin
                            rdaddr  <= rdaddr + DW'(1);
                            fetch   <= 1'b1;
                            lat_cnt <= '0;
                        end else if (sck_fall && bit_cnt != '0) begin
                            shout <= {shout[DW-2:0], 1'b0};
                        end
                    end
                    default: begin
                        state <= WAIT_CS;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Bench for spi_bus_bridge: host SPI driver, registered bus model for reads,
// and a write/read scoreboard checked scenario by scenario.
module tb_spi_bus_bridge;

    localparam int unsigned RD_LAT = 2;
    localparam int unsigned H      = 12;   // clk cycles per SCK half period

    logic        clk = 1'b0;
    logic        sclr;
    logic        spi_sck;
    logic        spi_csn;
    logic        spi_mosi;
    logic        spi_miso;
    logic [15:0] rdaddr;
    logic [15:0] wraddr;
    logic [1:0]  be;
    logic        write;
    logic [15:0] wrdata;
    logic [15:0] rddata;
    logic        busy;
    logic        frame_err;

    always #5 clk = ~clk;

    spi_bus_bridge #(.SYNC_STAGES(2), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .sclr      (sclr),
        .spi_sck   (spi_sck),
        .spi_csn   (spi_csn),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .rdaddr    (rdaddr),
        .wraddr    (wraddr),
        .be        (be),
        .write     (write),
        .wrdata    (wrdata),
        .rddata    (rddata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    // Bus model: data = addr ^ 5A5A, valid RD_LAT clocks after rdaddr changes
    logic [15:0] rd_pipe0;
    logic [15:0] rd_pipe1;
    always @(posedge clk) begin
        rd_pipe0 <= rdaddr ^ 16'h5A5A;
        rd_pipe1 <= rd_pipe0;
    end
    assign rddata = rd_pipe1;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [15:0] rd_q[$];
    int          errors = 0;
    int          checks = 0;
    int          rd_ptr = 0;
    int          wr_seen = 0;
    int          err_seen = 0;
    logic [15:0] obs_addr [64];
    logic [15:0] obs_data [64];
    logic [1:0]  obs_be   [64];

    always @(negedge clk) begin
        if (write) begin
            obs_addr[wr_seen[5:0]] = wraddr;
            obs_data[wr_seen[5:0]] = wrdata;
            obs_be[wr_seen[5:0]]   = be;
            wr_seen++;
        end
        if (frame_err) begin
            err_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_word(input logic [15:0] tx, input int nbits, output logic [15:0] rx);
        rx = '0;
        for (int i = 15; i >= 16 - nbits; i--) begin
            spi_mosi = tx[i];
            tick(H);
            spi_sck = 1'b1;
            rx = {rx[14:0], spi_miso};
            tick(H);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_csn = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        tick(4);
        spi_csn = 1'b1;
        tick(8);
    endtask

    task automatic check_writes(input string name);
        wr_t e;
        while (wr_q.size() > 0) begin
            e = wr_q.pop_front();
            checks++;
            if (rd_ptr >= wr_seen) begin
                errors++;
                $display("FAIL %s: write missing, got none, expected addr=%h data=%h", name, e.addr, e.data);
            end else if (obs_addr[rd_ptr[5:0]] !== e.addr || obs_data[rd_ptr[5:0]] !== e.data
                         || obs_be[rd_ptr[5:0]] !== 2'b11) begin
                errors++;
                $display("FAIL %s: got addr=%h data=%h be=%b, expected addr=%h data=%h be=11",
                         name, obs_addr[rd_ptr[5:0]], obs_data[rd_ptr[5:0]], obs_be[rd_ptr[5:0]],
                         e.addr, e.data);
            end
            rd_ptr++;
        end
        checks++;
        if (wr_seen != rd_ptr) begin
            errors++;
            $display("FAIL %s_count: got %0d write pulses, expected %0d", name, wr_seen, rd_ptr);
            rd_ptr = wr_seen;
        end
    endtask

    task automatic test_reset();
        sclr     = 1'b1;
        spi_csn  = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        tick(3);
        sclr = 1'b0;
        tick(1);
        checks += 8;
        if (write !== 1'b0)      begin errors++; $display("FAIL reset_write: got %b expected 0", write); end
        if (wraddr !== 16'h0)    begin errors++; $display("FAIL reset_wraddr: got %h expected 0000", wraddr); end
        if (rdaddr !== 16'h0)    begin errors++; $display("FAIL reset_rdaddr: got %h expected 0000", rdaddr); end
        if (wrdata !== 16'h0)    begin errors++; $display("FAIL reset_wrdata: got %h expected 0000", wrdata); end
        if (be !== 2'b00)        begin errors++; $display("FAIL reset_be: got %b expected 00", be); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        if (spi_miso !== 1'b0)   begin errors++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
        tick(8);
    endtask

    task automatic test_write();
        logic [15:0] rx;
        cs_low();
        spi_word(16'h8180, 16, rx);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_open: got %b expected 1", busy); end
        wr_q.push_back('{addr: 16'h0180, data: 16'h1234});
        spi_word(16'h1234, 16, rx);
        tick(4);
        check_writes("write_single");
        cs_high();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_closed: got %b expected 0", busy); end
    endtask

    task automatic test_burst_write();
        logic [15:0] rx;
        cs_low();
        spi_word(16'hFFFF, 16, rx);
        wr_q.push_back('{addr: 16'h7FFF, data: 16'hAAAA});
        spi_word(16'hAAAA, 16, rx);
        wr_q.push_back('{addr: 16'h8000, data: 16'hBBBB});
        spi_word(16'hBBBB, 16, rx);
        wr_q.push_back('{addr: 16'h8001, data: 16'hCCCC});
        spi_word(16'hCCCC, 16, rx);
        tick(4);
        check_writes("burst_write");
        cs_high();
    endtask

    task automatic test_read();
        logic [15:0] rx;
        logic [15:0] exp;
        rd_q.push_back(16'h5B5A);
        cs_low();
        spi_word(16'h0100, 16, rx);
        checks++;
        if (rx !== 16'h0000) begin errors++; $display("FAIL read_hdr_miso: got %h expected 0000", rx); end
        spi_word(16'h0000, 16, rx);
        exp = rd_q.pop_front();
        checks++;
        if (rx !== exp) begin errors++; $display("FAIL read_word: got %h expected %h", rx, exp); end
        cs_high();
        check_writes("read_no_write");
    endtask

    task automatic test_burst_read();
        logic [15:0] rx;
        logic [15:0] exp;
        for (int k = 0; k < 4; k++) begin
            rd_q.push_back((16'h01C0 + 16'(k)) ^ 16'h5A5A);
        end
        cs_low();
        spi_word(16'h01C0, 16, rx);
        for (int k = 0; k < 4; k++) begin
            spi_word(16'hFFFF, 16, rx);
            exp = rd_q.pop_front();
            checks++;
            if (rx !== exp) begin errors++; $display("FAIL burst_read_w%0d: got %h expected %h", k, rx, exp); end
        end
        cs_high();
        checks++;
        if (rdaddr !== 16'h01C4) begin errors++; $display("FAIL burst_read_rdaddr: got %h expected 01c4", rdaddr); end
        check_writes("burst_read_no_write");
    endtask

    task automatic test_frame_err();
        logic [15:0] rx;
        int e0;
        e0 = err_seen;
        cs_low();
        spi_word(16'h8040, 16, rx);
        spi_word(16'h1111, 9, rx);
        cs_high();
        checks += 2;
        if (err_seen - e0 !== 1) begin errors++; $display("FAIL frame_err_pulse: got %0d cycles expected 1", err_seen - e0); end
        if (busy !== 1'b0) begin errors++; $display("FAIL frame_err_busy: got %b expected 0", busy); end
        check_writes("frame_err_no_write");
        e0 = err_seen;
        cs_low();
        spi_word(16'h8041, 16, rx);
        wr_q.push_back('{addr: 16'h0041, data: 16'h2222});
        spi_word(16'h2222, 16, rx);
        cs_high();
        check_writes("frame_err_recover");
        checks++;
        if (err_seen !== e0) begin errors++; $display("FAIL frame_err_clean_end: got %0d pulses expected 0", err_seen - e0); end
    endtask

    task automatic test_sclr_mid();
        logic [15:0] rx;
        int e0;
        cs_low();
        spi_word(16'h8200, 16, rx);
        spi_word(16'h3333, 8, rx);
        sclr = 1'b1;
        tick(1);
        sclr = 1'b0;
        checks += 5;
        if (wraddr !== 16'h0) begin errors++; $display("FAIL sclr_wraddr: got %h expected 0000", wraddr); end
        if (rdaddr !== 16'h0) begin errors++; $display("FAIL sclr_rdaddr: got %h expected 0000", rdaddr); end
        if (wrdata !== 16'h0) begin errors++; $display("FAIL sclr_wrdata: got %h expected 0000", wrdata); end
        if (be !== 2'b00)     begin errors++; $display("FAIL sclr_be: got %b expected 00", be); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL sclr_busy: got %b expected 0", busy); end
        e0 = err_seen;
        spi_word(16'h4444, 8, rx);
        spi_word(16'h8300, 16, rx);
        spi_word(16'h6666, 16, rx);
        tick(4);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL sclr_ignored_busy: got %b expected 0", busy); end
        check_writes("sclr_ignored");
        cs_high();
        checks++;
        if (err_seen !== e0) begin errors++; $display("FAIL sclr_no_err: got %0d pulses expected 0", err_seen - e0); end
        cs_low();
        spi_word(16'h8005, 16, rx);
        wr_q.push_back('{addr: 16'h0005, data: 16'hBEEF});
        spi_word(16'hBEEF, 16, rx);
        cs_high();
        check_writes("sclr_new_frame");
    endtask

    initial begin
        test_reset();
        test_write();
        test_burst_write();
        test_read();
        test_burst_read();
        test_frame_err();
        test_sclr_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
